wb_skid_stage: RTL and testbench

- Parametrised successor to the MEM->WB pipeline register, with a valid/ready handshake and a 2-entry skid buffer.
- The upstream MEM stage can keep streaming while writeback back-pressures, and a flush input clears in-flight results.
- Sits between the data-memory stage and the register-file write port.
- Also provides the muxed writeback value and a gated write enable, so the register file needs no extra glue.

---
 rtl/wb_skid_stage_pkg.sv | 30 +++
 rtl/wb_skid_stage_skid_buffer2.sv | 83 ++++++++
 rtl/wb_skid_stage.sv | 71 +++++++
 tb/tb_wb_skid_stage.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_skid_stage_pkg.sv
// rtl/wb_skid_stage_pkg.sv - shared types and constants for the MEM->WB skid stage
package wb_skid_stage_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Occupancy of the two-entry skid; the value 3 is unused and recovers to empty
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Writeback payload at the default pipeline widths
  typedef struct packed {
    logic                 reg_write;
    logic                 mem_to_reg;
    logic [WB_DATA_W-1:0] mem_data;
    logic [WB_DATA_W-1:0] alu_result;
    logic [WB_ADDR_W-1:0] rd_addr;
  } wb_payload_t;

  localparam wb_payload_t WB_PAYLOAD_ZERO = '0;

  // Bit width of a writeback payload for arbitrary data/address widths
  function automatic int payload_width(input int data_w, input int addr_w);
    return 2 + 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/wb_skid_stage_skid_buffer2.sv
// rtl/wb_skid_stage_skid_buffer2.sv - generic 2-entry valid/ready skid buffer with flush
module skid_buffer2
  import wb_skid_stage_pkg::*;
#(
  parameter int W           = 8,
  parameter bit RESET_READY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state, state_n;
  logic [W-1:0] head, head_n;
  logic [W-1:0] skid, skid_n;
  logic         ready_q;
  logic         in_fire, out_fire;

  assign in_ready  = ready_q;
  assign out_valid = (state == SKID_ONE) || (state == SKID_TWO);
  assign out_data  = head;
  assign in_fire   = in_valid & ready_q;
  assign out_fire  = out_valid & out_ready;

  // Next occupancy and register loads; flush wins and leaves data untouched
  always_comb begin
    state_n = state;
    head_n  = head;
    skid_n  = skid;
    case (state)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_n = SKID_ONE;
          head_n  = in_data;
        end
      end
      SKID_ONE: begin
        if (in_fire && out_fire) begin
          head_n = in_data;
        end else if (out_fire) begin
          state_n = SKID_EMPTY;
        end else if (in_fire) begin
          state_n = SKID_TWO;
          skid_n  = in_data;
        end
      end
      SKID_TWO: begin
        if (out_fire) begin
          state_n = SKID_ONE;
          head_n  = skid;
        end
      end
      default: state_n = SKID_EMPTY;
    endcase
    if (flush) begin
      state_n = SKID_EMPTY;
      head_n  = head;
      skid_n  = skid;
    end
  end

  // State, storage and registered ready; ready looks only at the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SKID_EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= RESET_READY;
    end else begin
      state   <= state_n;
      head    <= head_n;
      skid    <= skid_n;
      ready_q <= (state_n != SKID_TWO);
    end
  end

endmodule

// File: rtl/wb_skid_stage.sv
// rtl/wb_skid_stage.sv - MEM->WB pipeline stage with skid buffer, writeback mux and gated write enable
module wb_skid_stage
  import wb_skid_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter bit RESET_READY = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [DATA_W-1:0] dataMem_data_i,
  input  logic [DATA_W-1:0] ALU_result_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] dataMem_data_o,
  output logic [DATA_W-1:0] ALU_result_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] wb_data_o
);

  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] rd_addr;
  } payload_t;

  localparam int PW = payload_width(DATA_W, ADDR_W);

  payload_t in_payload;
  payload_t head_payload;

  assign in_payload.reg_write  = RegWrite_i;
  assign in_payload.mem_to_reg = MemtoReg_i;
  assign in_payload.mem_data   = dataMem_data_i;
  assign in_payload.alu_result = ALU_result_i;
  assign in_payload.rd_addr    = RDaddr_i;

  skid_buffer2 #(
    .W           (PW),
    .RESET_READY (RESET_READY)
  ) u_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (flush_i),
    .in_valid  (valid_i),
    .in_ready  (ready_o),
    .in_data   (in_payload),
    .out_valid (valid_o),
    .out_ready (ready_i),
    .out_data  (head_payload)
  );

  // Write enable is only meaningful for a valid head; rd 0 is left to the register file
  assign RegWrite_o     = head_payload.reg_write & valid_o;
  assign MemtoReg_o     = head_payload.mem_to_reg;
  assign dataMem_data_o = head_payload.mem_data;
  assign ALU_result_o   = head_payload.alu_result;
  assign RDaddr_o       = head_payload.rd_addr;
  assign wb_data_o      = head_payload.mem_to_reg ? head_payload.mem_data : head_payload.alu_result;

endmodule

// File: tb/tb_wb_skid_stage.sv
// tb/tb_wb_skid_stage.sv - randomized self-checking bench for wb_skid_stage
module tb_wb_skid_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        RegWrite_i = 1'b0;
  logic        MemtoReg_i = 1'b0;
  logic [31:0] dataMem_data_i = '0;
  logic [31:0] ALU_result_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        RegWrite_o;
  logic        MemtoReg_o;
  logic [31:0] dataMem_data_o;
  logic [31:0] ALU_result_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] wb_data_o;

  wb_skid_stage #(.DATA_W(32), .ADDR_W(5), .RESET_READY(1'b1)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .RegWrite_i     (RegWrite_i),
    .MemtoReg_i     (MemtoReg_i),
    .dataMem_data_i (dataMem_data_i),
    .ALU_result_i   (ALU_result_i),
    .RDaddr_i       (RDaddr_i),
    .flush_i        (flush_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .RegWrite_o     (RegWrite_o),
    .MemtoReg_o     (MemtoReg_o),
    .dataMem_data_o (dataMem_data_o),
    .ALU_result_o   (ALU_result_o),
    .RDaddr_o       (RDaddr_o),
    .wb_data_o      (wb_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rw;
    bit          mtr;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rd;
  } ent_t;

  ent_t q[$];
  bit   mrdy = 1'b1;
  int   acc_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  bit   m_in, m_out;
  ent_t m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of capacity two; ready is whether it is below capacity after the edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      mrdy = 1'b1;
    end else begin
      m_in  = valid_i && mrdy;
      m_out = (q.size() > 0) && ready_i;
      if (flush_i) begin
        q.delete();
      end else begin
        if (m_out) void'(q.pop_front());
        if (m_in) begin
          m_e.rw  = RegWrite_i;
          m_e.mtr = MemtoReg_i;
          m_e.mem = dataMem_data_i;
          m_e.alu = ALU_result_i;
          m_e.rd  = RDaddr_i;
          q.push_back(m_e);
          acc_cnt++;
        end
      end
      mrdy = (q.size() < 2);
    end
  end

  // Per-cycle comparison against the reference
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_o", valid_o, q.size() > 0);
      chk("ready_o", ready_o, mrdy);
      chk("regwrite_gated", RegWrite_o & ~valid_o, 0);
      if (q.size() > 0) begin
        chk("RegWrite_o", RegWrite_o, q[0].rw);
        chk("MemtoReg_o", MemtoReg_o, q[0].mtr);
        chk("dataMem_data_o", dataMem_data_o, q[0].mem);
        chk("ALU_result_o", ALU_result_o, q[0].alu);
        chk("RDaddr_o", RDaddr_o, q[0].rd);
        chk("wb_data_o", wb_data_o, q[0].mtr ? q[0].mem : q[0].alu);
      end
    end
  end

  task automatic drive(input bit v, input bit rw, input bit mtr,
                       input logic [31:0] mem, input logic [31:0] alu, input logic [4:0] rd);
    valid_i        = v;
    RegWrite_i     = rw;
    MemtoReg_i     = mtr;
    dataMem_data_i = mem;
    ALU_result_i   = alu;
    RDaddr_i       = rd;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, valid_o, 0);
    chk({tag, "_ready"}, ready_o, 1);
    chk({tag, "_regwrite"}, RegWrite_o, 0);
    chk({tag, "_memtoreg"}, MemtoReg_o, 0);
    chk({tag, "_mem"}, dataMem_data_o, 0);
    chk({tag, "_alu"}, ALU_result_o, 0);
    chk({tag, "_rd"}, RDaddr_o, 0);
    chk({tag, "_wb"}, wb_data_o, 0);
  endtask

  int cyc;

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single entry, one-cycle latency
    drive(1, 1, 0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5);
    ready_i = 1'b1;
    @(negedge clk);
    chk("single_valid", valid_o, 1);
    chk("single_wb", wb_data_o, 32'h0000_1234);
    chk("single_regwrite", RegWrite_o, 1);
    chk("single_rd", RDaddr_o, 5);
    idle();
    @(negedge clk);
    chk("single_drained", valid_o, 0);

    // Back-pressure fill to two entries, then drain in order
    ready_i = 1'b0;
    drive(1, 1, 1, 32'hAAAA_0000, 32'h0000_0011, 5'd3);
    @(negedge clk);
    drive(1, 0, 0, 32'h0000_0022, 32'h0000_BBBB, 5'd4);
    @(negedge clk);
    idle();
    chk("bp_ready_low", ready_o, 0);
    chk("bp_head_a", wb_data_o, 32'hAAAA_0000);
    @(negedge clk);
    chk("bp_head_stable", wb_data_o, 32'hAAAA_0000);
    chk("bp_ready_still_low", ready_o, 0);
    ready_i = 1'b1;
    @(negedge clk);
    chk("bp_head_b", wb_data_o, 32'h0000_BBBB);
    chk("bp_ready_back", ready_o, 1);
    @(negedge clk);
    chk("bp_empty", valid_o, 0);

    // Streaming at full throughput
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 0, 32'h0, i, 5'(i));
      @(negedge clk);
      chk("stream_wb", wb_data_o, i);
      chk("stream_ready", ready_o, 1);
    end
    idle();
    @(negedge clk);
    chk("stream_done", valid_o, 0);

    // Flush while holding one entry drops a same-cycle accepted input
    ready_i = 1'b0;
    drive(1, 1, 0, 32'h0, 32'h0000_0077, 5'd7);
    @(negedge clk);
    flush_i = 1'b1;
    drive(1, 1, 0, 32'h0, 32'h0000_0088, 5'd8);
    @(negedge clk);
    flush_i = 1'b0;
    idle();
    chk("flush_one_valid", valid_o, 0);
    chk("flush_one_regwrite", RegWrite_o, 0);
    @(negedge clk);
    chk("flush_one_nothing", valid_o, 0);

    // Flush while full with a simultaneous input
    drive(1, 1, 0, 32'h0, 32'h0000_00A1, 5'd1);
    @(negedge clk);
    drive(1, 1, 0, 32'h0, 32'h0000_00A2, 5'd2);
    @(negedge clk);
    chk("flush_two_full", ready_o, 0);
    flush_i = 1'b1;
    drive(1, 1, 0, 32'h0, 32'h0000_00A3, 5'd3);
    @(negedge clk);
    flush_i = 1'b0;
    idle();
    chk("flush_two_valid", valid_o, 0);
    chk("flush_two_regwrite", RegWrite_o, 0);
    chk("flush_two_ready", ready_o, 1);
    ready_i = 1'b1;
    drive(1, 1, 0, 32'h0, 32'h0000_0055, 5'd9);
    @(negedge clk);
    idle();
    chk("after_flush_valid", valid_o, 1);
    chk("after_flush_wb", wb_data_o, 32'h0000_0055);
    @(negedge clk);
    chk("after_flush_alone", valid_o, 0);

    // Asynchronous reset in the middle of a full stall
    ready_i = 1'b0;
    drive(1, 1, 1, 32'h1111_2222, 32'h3333_4444, 5'd10);
    @(negedge clk);
    drive(1, 1, 1, 32'h5555_6666, 32'h7777_8888, 5'd11);
    @(negedge clk);
    idle();
    chk("pre_reset_full", ready_o, 0);
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_empty", valid_o, 0);

    // Random entries with ready alternating each cycle
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 20 && cyc < 500) begin
      ready_i = cyc[0];
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, 5'($urandom_range(0, 31)));
      @(negedge clk);
      cyc++;
    end
    idle();
    chk("random_accepted_20", acc_cnt >= 20, 1);
    ready_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("random_drained_model", q.size(), 0);
    chk("random_drained_dut", valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
